// File: rtl/md_issue_ctrl.sv
// Execute-stage issue controller for the mul_div unit: launches mult/div ops,
// tracks Busy, owns the architectural HI/LO registers and stalls F/D/E while an MD op must wait.
module md_issue_ctrl #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_rs,
  input  logic [WIDTH-1:0] req_rt,
  input  logic             flush,
  output logic             stall,
  output logic             md_start,
  output logic [2:0]       md_op,
  output logic [WIDTH-1:0] md_a,
  output logic [WIDTH-1:0] md_b,
  input  logic             md_busy,
  input  logic [WIDTH-1:0] md_hi,
  input  logic [WIDTH-1:0] md_lo,
  output logic [WIDTH-1:0] rd_data,
  output logic             timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_seen;
  logic [CNT_W-1:0]   wait_cnt;

  logic acc, is_md, done, expired;

  assign acc     = req_valid & ~flush & (req_op >= 4'd1) & (req_op <= 4'd8);
  assign is_md   = acc & (req_op <= 4'd4);
  // Busy must have been observed high first, so a late-rising Busy is not taken as done.
  assign done    = ~md_busy & busy_seen;
  assign expired = (wait_cnt == CNT_W'(MAX_WAIT - 1));

  assign md_a = req_rs;
  assign md_b = req_rt;

  always_comb begin
    stall    = 1'b0;
    md_start = 1'b0;
    md_op    = 3'd0;
    rd_data  = '0;
    if (state == RUN) begin
      stall = acc;
    end else begin
      md_start = is_md;
      if (is_md) md_op = req_op[2:0];
      if (acc && req_op == 4'd5) rd_data = hi_q;
      if (acc && req_op == 4'd6) rd_data = lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_seen <= 1'b0;
      wait_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            state     <= RUN;
            busy_seen <= 1'b0;
            wait_cnt  <= '0;
          end else if (acc && req_op == 4'd7) begin
            hi_q <= req_rs;
          end else if (acc && req_op == 4'd8) begin
            lo_q <= req_rs;
          end
        end
        RUN: begin
          if (md_busy) busy_seen <= 1'b1;
          wait_cnt <= wait_cnt + 1'b1;
          if (done) begin
            hi_q  <= md_hi;
            lo_q  <= md_lo;
            state <= IDLE;
          end else if (expired) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios plus random traffic against a
// cycle-level reference of HI/LO, the in-flight op and a mul_div unit model.
module tb_md_issue_ctrl;
  localparam int WIDTH    = 32;
  localparam int MAX_WAIT = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, flush;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_rs, req_rt;
  logic             stall, md_start, md_busy, timeout;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] md_a, md_b, md_hi, md_lo, rd_data;

  md_issue_ctrl #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .flush(flush), .stall(stall),
    .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
    .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo), .rd_data(rd_data),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  logic [31:0] m_hi, m_lo;
  logic        m_run, m_seen, m_timeout;
  int          m_cnt;
  // mul_div unit model
  logic [31:0] u_hi, u_lo;
  int          busy_left;
  int          next_lat;
  logic        hang;

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_run = 0; m_seen = 0; m_timeout = 0; m_cnt = 0;
    busy_left = 0; hang = 0; u_hi = 0; u_lo = 0; md_hi = 0; md_lo = 0;
  endtask

  task automatic compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    case (op)
      4'd1: begin p = longint'($signed(a)) * longint'($signed(b)); u_hi = p[63:32]; u_lo = p[31:0]; end
      4'd2: begin p = longint'({32'd0, a}) * longint'({32'd0, b}); u_hi = p[63:32]; u_lo = p[31:0]; end
      4'd3: begin u_lo = $signed(a) / $signed(b); u_hi = $signed(a) % $signed(b); end
      default: begin u_lo = a / b; u_hi = a % b; end
    endcase
    md_hi = u_hi; md_lo = u_lo;
  endtask

  // one clock of stimulus: predict, compare mid-cycle, then advance the reference
  task automatic drive_cycle(input logic v, input logic [3:0] op, input logic [31:0] rs,
                             input logic [31:0] rt, input logic fl);
    logic acc, e_start, e_stall, busy_now;
    logic [2:0] e_op;
    logic [31:0] e_rd;
    req_valid = v; req_op = op; req_rs = rs; req_rt = rt; flush = fl;
    busy_now = hang || (busy_left > 0);
    md_busy = busy_now;
    acc = v && !fl && op >= 1 && op <= 8;
    e_start = !m_run && acc && op <= 4;
    e_stall = m_run && acc;
    e_op = 3'd0;
    if (e_start) e_op = op[2:0];
    e_rd = 0;
    if (!m_run && acc && op == 4'd5) e_rd = m_hi;
    if (!m_run && acc && op == 4'd6) e_rd = m_lo;
    #3;
    n_vec++; if (stall !== e_stall) begin n_err++; $display("FAIL stall op=%0d got %b exp %b", op, stall, e_stall); end
    n_vec++; if (md_start !== e_start) begin n_err++; $display("FAIL md_start op=%0d got %b exp %b", op, md_start, e_start); end
    n_vec++; if (md_op !== e_op) begin n_err++; $display("FAIL md_op got %0d exp %0d", md_op, e_op); end
    n_vec++; if (rd_data !== e_rd) begin n_err++; $display("FAIL rd_data op=%0d got %h exp %h", op, rd_data, e_rd); end
    n_vec++; if (timeout !== m_timeout) begin n_err++; $display("FAIL timeout got %b exp %b", timeout, m_timeout); end
    if (e_start) begin
      n_vec++; if (md_a !== rs || md_b !== rt) begin n_err++; $display("FAIL operands got %h/%h exp %h/%h", md_a, md_b, rs, rt); end
    end
    if (!m_run) begin
      if (e_start) begin m_run = 1; m_cnt = 0; m_seen = 0; compute(op, rs, rt); end
      else if (acc && op == 4'd7) m_hi = rs;
      else if (acc && op == 4'd8) m_lo = rs;
    end else begin
      if (!busy_now && m_seen) begin m_hi = u_hi; m_lo = u_lo; m_run = 0; end
      else if (m_cnt == MAX_WAIT - 1) begin m_timeout = 1; m_run = 0; end
      if (busy_now) m_seen = 1;
      m_cnt++;
    end
    if (busy_left > 0) busy_left--;
    if (e_start) busy_left = next_lat;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b1; req_op = 4'd5; req_rs = 0; req_rt = 0; flush = 0; md_busy = 0;
    model_reset();
    #3;
    n_vec++; if ({stall, md_start, md_op, timeout} !== 6'd0) begin n_err++; $display("FAIL reset_ctl got %b exp 0", {stall, md_start, md_op, timeout}); end
    n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL reset_rd got %h exp 0", rd_data); end
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cycle();
  endtask

  task automatic test_mult_then_mflo();
    next_lat = 3;
    drive_cycle(1'b1, 4'd1, 32'd17, 32'd21, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic was_run;
      was_run = m_run;
      drive_cycle(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
      if (!was_run) break;
    end
    n_vec++; if (m_run !== 1'b0 || m_lo !== 32'd357) begin n_err++; $display("FAIL mult_done lo %0d exp 357", m_lo); end
    drive_cycle(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_mthi_mfhi();
    drive_cycle(1'b1, 4'd7, 32'hDEADBEEF, 32'd0, 1'b0);
    drive_cycle(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    drive_cycle(1'b1, 4'd8, 32'h0BADF00D, 32'd0, 1'b0);
    drive_cycle(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_flush();
    next_lat = 2;
    drive_cycle(1'b1, 4'd3, 32'd100, 32'd7, 1'b1);
    drive_cycle(1'b1, 4'd7, 32'h11111111, 32'd0, 1'b1);
    drive_cycle(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    drive_cycle(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
    // flush during an in-flight op: the op still commits
    drive_cycle(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
    drive_cycle(1'b1, 4'd6, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 6; i++) idle_cycle();
    drive_cycle(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
    drive_cycle(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    next_lat = 8;
    drive_cycle(1'b1, 4'd4, 32'd1000, 32'd3, 1'b0);
    idle_cycle();
    idle_cycle();
    req_valid = 1'b1; req_op = 4'd6; flush = 1'b0;
    reset = 1'b0;
    #3;
    n_vec++; if (stall !== 1'b0 || md_start !== 1'b0) begin n_err++; $display("FAIL midrun_stall got %b%b exp 00", stall, md_start); end
    n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL midrun_rd got %h exp 0", rd_data); end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) idle_cycle();
    drive_cycle(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      logic [31:0] rs, rt;
      op = 4'($urandom_range(0, 10));
      rs = $urandom;
      rt = (op == 4'd3 || op == 4'd4) ? 32'($urandom_range(1, 1000)) : $urandom;
      next_lat = $urandom_range(1, 5);
      drive_cycle(($urandom % 4) != 0, op, rs, rt, ($urandom % 8) == 0);
    end
    for (int i = 0; i < 8; i++) idle_cycle();
  endtask

  task automatic test_timeout();
    drive_cycle(1'b1, 4'd7, 32'h00001234, 32'd0, 1'b0);
    drive_cycle(1'b1, 4'd8, 32'h00005678, 32'd0, 1'b0);
    hang = 1'b1;
    drive_cycle(1'b1, 4'd1, 32'd5, 32'd6, 1'b0);
    for (int i = 0; i < MAX_WAIT + 2; i++) drive_cycle(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    hang = 1'b0;
    n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL timeout_flag got %b exp 1", timeout); end
    drive_cycle(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    drive_cycle(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
    next_lat = 2;
    drive_cycle(1'b1, 4'd2, 32'd3, 32'd4, 1'b0);
    for (int i = 0; i < 5; i++) idle_cycle();
    drive_cycle(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    next_lat = 1;
    test_reset();
    test_mult_then_mflo();
    test_mthi_mfhi();
    test_flush();
    test_reset_mid_run();
    test_random();
    test_timeout();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
